// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: N:1 AXI stream arbiter with packet-granular round-robin.
// A grant is taken in IDLE and held until the granted packet's tlast beat is
// accepted, so packets from different sources never interleave. The data path
// is a purely combinational mux steered by the registered grant; the source
// index is forwarded on axis_o_tid.
module axis_packet_arbiter #(
    parameter int unsigned AXIS_BYTES  = 1,
    parameter int unsigned NUM_STREAMS = 2,
    localparam int unsigned ID_W       = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1,
    localparam int unsigned DW         = AXIS_BYTES * 8
) (
    input  logic                        clk,
    input  logic                        sreset,

    output logic [NUM_STREAMS-1:0]      axis_i_tready,
    input  logic [NUM_STREAMS-1:0]      axis_i_tvalid,
    input  logic [NUM_STREAMS-1:0]      axis_i_tlast,
    input  logic [NUM_STREAMS*DW-1:0]   axis_i_tdata,

    input  logic                        axis_o_tready,
    output logic                        axis_o_tvalid,
    output logic                        axis_o_tlast,
    output logic [DW-1:0]               axis_o_tdata,
    output logic [ID_W-1:0]             axis_o_tid
);

    typedef enum logic {
        StIdle,
        StLocked
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   last_q,  last_d;

    // Round-robin pick results
    logic              any_valid;
    logic              hi_found;
    logic [ID_W-1:0]   hi_idx;
    logic [ID_W-1:0]   lo_idx;
    logic [ID_W-1:0]   pick_idx;

    // Granted-input fields
    logic              sel_valid;
    logic              sel_last;
    logic [DW-1:0]     sel_data;

    logic              pkt_end;

    // Round-robin pick: lowest valid index above last, else lowest valid overall.
    // Scanning downward lets the final assignment in each class be the lowest.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (axis_i_tvalid[i]) begin
                lo_idx = ID_W'(i);
                if (ID_W'(i) > last_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
        any_valid = |axis_i_tvalid;
        pick_idx  = hi_found ? hi_idx : lo_idx;
    end

    // Mux the granted input's fields; grant always steers data, last and tid.
    always_comb begin
        sel_valid = axis_i_tvalid[0];
        sel_last  = axis_i_tlast[0];
        sel_data  = axis_i_tdata[DW-1:0];
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (grant_q == ID_W'(i)) begin
                sel_valid = axis_i_tvalid[i];
                sel_last  = axis_i_tlast[i];
                sel_data  = axis_i_tdata[i*DW +: DW];
            end
        end
    end

    // Output handshake: only tvalid and the granted tready are gated by state.
    always_comb begin
        axis_o_tdata  = sel_data;
        axis_o_tlast  = sel_last;
        axis_o_tid    = grant_q;
        axis_o_tvalid = 1'b0;
        axis_i_tready = '0;
        if (state_q == StLocked) begin
            axis_o_tvalid = sel_valid;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                if (grant_q == ID_W'(i)) begin
                    axis_i_tready[i] = axis_o_tready;
                end
            end
        end
    end

    assign pkt_end = axis_o_tvalid && axis_o_tready && axis_o_tlast;

    // Next-state: grab a source in IDLE, release it once its tlast beat is taken.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    grant_d = pick_idx;
                    state_d = StLocked;
                end
            end
            StLocked: begin
                if (pkt_end) begin
                    last_d  = grant_q;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset leaves last at the top index so input 0 wins first.
    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= ID_W'(NUM_STREAMS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter (4 streams, 1 byte): directed scenarios with a
// behavioural arbiter model checked every cycle plus literal transfer logs.
module tb_axis_packet_arbiter;

    localparam int NS = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic                clk = 1'b0;
    logic                sreset;
    logic [NS-1:0]       i_tready;
    logic [NS-1:0]       i_tvalid;
    logic [NS-1:0]       i_tlast;
    logic [NS*DW-1:0]    i_tdata;
    logic                o_tready;
    logic                o_tvalid;
    logic                o_tlast;
    logic [DW-1:0]       o_tdata;
    logic [IW-1:0]       o_tid;

    axis_packet_arbiter #(
        .AXIS_BYTES  (1),
        .NUM_STREAMS (NS)
    ) dut (
        .clk           (clk),
        .sreset        (sreset),
        .axis_i_tready (i_tready),
        .axis_i_tvalid (i_tvalid),
        .axis_i_tlast  (i_tlast),
        .axis_i_tdata  (i_tdata),
        .axis_o_tready (o_tready),
        .axis_o_tvalid (o_tvalid),
        .axis_o_tlast  (o_tlast),
        .axis_o_tdata  (o_tdata),
        .axis_o_tid    (o_tid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accepted-transfer log, appended on every output handshake
    int log_tid[$];
    int log_data[$];
    int log_last[$];
    int log_cyc[$];
    int cyc = 0;
    bit acc[NS];

    // Arbiter model: busy flag, current owner, previous owner
    int m_busy  = 0;
    int m_grant = 0;
    int m_last  = NS - 1;
    bit m_ok    = 0;

    // Compare process: check outputs against the model, then advance the model.
    always @(negedge clk) begin : compare
        logic ev;
        int   p;
        for (int i = 0; i < NS; i++) acc[i] = (i_tvalid[i] && i_tready[i]);
        if (o_tvalid === 1'b1 && o_tready) begin
            log_tid.push_back(int'(o_tid));
            log_data.push_back(int'(o_tdata));
            log_last.push_back(int'(o_tlast));
            log_cyc.push_back(cyc);
        end
        ev = (m_busy != 0) && i_tvalid[m_grant];
        if (m_ok) begin
            chk("tvalid", o_tvalid, ev);
            chk("tid", o_tid, m_grant);
            chk("tdata", o_tdata, i_tdata[m_grant*DW +: DW]);
            chk("tlast", o_tlast, i_tlast[m_grant]);
            for (int i = 0; i < NS; i++)
                chk($sformatf("tready%0d", i), i_tready[i],
                    (m_busy != 0) && (i == m_grant) && o_tready);
        end
        if (sreset) begin
            m_busy  = 0;
            m_grant = 0;
            m_last  = NS - 1;
            m_ok    = 1;
        end else if (m_busy == 0) begin
            for (int k = 1; k <= NS; k++) begin
                p = (m_last + k) % NS;
                if (i_tvalid[p] && m_busy == 0) begin
                    m_grant = p;
                    m_busy  = 1;
                end
            end
        end else if (ev && o_tready && i_tlast[m_grant]) begin
            m_last = m_grant;
            m_busy = 0;
        end
        cyc++;
    end

    // Per-input sources: beat = data | last<<8 | gap<<12 (idle cycles before it)
    int src_q[NS][$];
    int hold[NS];

    function automatic int beat(input int data, input int last, input int gap);
        return data | (last << 8) | (gap << 12);
    endfunction

    task automatic drive();
        int b;
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                i_tvalid[i]          = (hold[i] == 0);
                i_tdata[i*DW +: DW]  = b[7:0];
                i_tlast[i]           = b[8];
            end else begin
                i_tvalid[i]          = 1'b0;
                i_tdata[i*DW +: DW]  = '0;
                i_tlast[i]           = 1'b0;
            end
        end
    endtask

    task automatic tick();
        int b;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (acc[i]) begin
                void'(src_q[i].pop_front());
                hold[i] = 0;
                if (src_q[i].size() > 0) begin
                    b       = src_q[i][0];
                    hold[i] = b >> 12;
                end
            end else if (hold[i] > 0) begin
                hold[i]--;
            end
        end
        drive();
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (log_tid.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk({name, "_timeout"}, log_tid.size() >= n, 1);
    endtask

    task automatic clear_log();
        log_tid.delete();
        log_data.delete();
        log_last.delete();
        log_cyc.delete();
    endtask

    task automatic chk_log(input int n, input int tid, input int data, input int last);
        if (log_tid.size() > n) begin
            chk($sformatf("log%0d_tid", n), log_tid[n], tid);
            chk($sformatf("log%0d_data", n), log_data[n], data);
            chk($sformatf("log%0d_last", n), log_last[n], last);
        end else begin
            chk($sformatf("log%0d_missing", n), log_tid.size(), n + 1);
        end
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int rel;
        int c;
        sreset   = 1'b1;
        o_tready = 1'b1;
        i_tvalid = '0;
        i_tlast  = '0;
        i_tdata  = '0;
        for (int i = 0; i < NS; i++) hold[i] = 0;

        // Reset with everyone valid, then fairness: two 3-beat packets per input
        for (int i = 0; i < NS; i++)
            for (int p = 0; p < 2; p++)
                for (int b = 0; b < 3; b++)
                    src_q[i].push_back(beat(i * 16 + b, (b == 2) ? 1 : 0, 0));
        drive();
        tick();
        tick();
        sreset = 1'b0;
        rel    = cyc;
        @(negedge clk);
        chk("rst_tvalid", o_tvalid, 0);
        chk("rst_tready", i_tready, 0);
        chk("rst_tid", o_tid, 0);
        wait_log(24, 100, "fair");
        if (log_cyc.size() > 0) chk("fair_first_cycle", log_cyc[0], rel + 1);
        for (int n = 0; n < 24 && n < log_tid.size(); n++) begin
            chk_log(n, (n / 3) % 4, ((n / 3) % 4) * 16 + n % 3, (n % 3 == 2) ? 1 : 0);
            chk($sformatf("fair%0d_cyc", n), log_cyc[n], log_cyc[0] + (n / 3) * 4 + n % 3);
        end

        // Backpressure and gaps: input 2 with a 2-cycle gap, input 1 waiting
        repeat (3) tick();
        clear_log();
        src_q[2].push_back(beat(8'hA0, 0, 0));
        src_q[2].push_back(beat(8'hA1, 0, 0));
        src_q[2].push_back(beat(8'hA2, 0, 2));
        src_q[2].push_back(beat(8'hA3, 1, 0));
        drive();
        tick();
        src_q[1].push_back(beat(8'hB0, 1, 0));
        drive();
        c = 0;
        while (log_tid.size() < 5 && c < 60) begin
            tick();
            o_tready = ~o_tready;
            c++;
        end
        o_tready = 1'b1;
        chk("bp_timeout", log_tid.size() >= 5, 1);
        chk_log(0, 2, 8'hA0, 0);
        chk_log(1, 2, 8'hA1, 0);
        chk_log(2, 2, 8'hA2, 0);
        chk_log(3, 2, 8'hA3, 1);
        chk_log(4, 1, 8'hB0, 1);
        if (log_cyc.size() >= 5) chk("bp_b0_after_bubble", log_cyc[4] >= log_cyc[3] + 2, 1);

        // Single-beat packets alternating between inputs 0 and 3
        repeat (3) tick();
        clear_log();
        src_q[0].push_back(beat(8'hC0, 1, 0));
        src_q[0].push_back(beat(8'hC1, 1, 0));
        drive();
        tick();
        src_q[3].push_back(beat(8'hD0, 1, 0));
        src_q[3].push_back(beat(8'hD1, 1, 0));
        drive();
        wait_log(4, 40, "single");
        chk_log(0, 0, 8'hC0, 1);
        chk_log(1, 3, 8'hD0, 1);
        chk_log(2, 0, 8'hC1, 1);
        chk_log(3, 3, 8'hD1, 1);
        for (int n = 1; n < 4 && n < log_cyc.size(); n++)
            chk($sformatf("single%0d_spacing", n), log_cyc[n] - log_cyc[n-1], 2);

        // Reset in the middle of a 5-beat packet from input 1
        repeat (3) tick();
        clear_log();
        for (int b = 0; b < 5; b++) src_q[1].push_back(beat(8'hE0 + b, (b == 4) ? 1 : 0, 0));
        src_q[3].push_back(beat(8'hF0, 1, 0));
        drive();
        wait_log(2, 20, "midrst_pre");
        sreset   = 1'b1;
        o_tready = 1'b0;
        tick();
        sreset   = 1'b0;
        o_tready = 1'b1;
        rel      = cyc;
        @(negedge clk);
        chk("midrst_tvalid", o_tvalid, 0);
        chk("midrst_tready", i_tready, 0);
        wait_log(6, 40, "midrst_post");
        chk_log(0, 1, 8'hE0, 0);
        chk_log(1, 1, 8'hE1, 0);
        chk_log(2, 1, 8'hE2, 0);
        chk_log(3, 1, 8'hE3, 0);
        chk_log(4, 1, 8'hE4, 1);
        chk_log(5, 3, 8'hF0, 1);
        if (log_cyc.size() >= 3) chk("midrst_regrant_cycle", log_cyc[2], rel + 1);

        // Idle for 10 cycles, then a lone single-beat request on input 1
        tick();
        clear_log();
        repeat (10) begin
            tick();
            @(negedge clk);
            chk("idle_tvalid", o_tvalid, 0);
        end
        tick();
        rel = cyc;
        src_q[1].push_back(beat(8'h55, 1, 0));
        drive();
        wait_log(1, 20, "idle_req");
        chk_log(0, 1, 8'h55, 1);
        if (log_cyc.size() >= 1) chk("idle_req_cycle", log_cyc[0], rel + 1);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Shares one AXI stream output among NUM_STREAMS input streams with packet-granular round-robin arbitration. A grant is held from the first beat of a packet until its tlast beat is accepted, so packets are never interleaved. It is the N:1 counterpart of the broadcaster and sits in front of any single shared consumer, such as a transmit MAC or a shared register stage. The source index is forwarded on a tid sideband so downstream logic can route responses.

## Interface
- AXIS_BYTES, 1, data width in bytes; tdata is AXIS_BYTES*8 bits.
- NUM_STREAMS, 2, number of input streams; must be ≥1.
- ID_W, derived as max(1, $clog2(NUM_STREAMS)), width of axis_o_tid; not user-set.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- sreset  in  1  synchronous, active-high reset.
- axis_i_tready  out  NUM_STREAMS  per-input ready.
- axis_i_tvalid  in  NUM_STREAMS  per-input valid.
- axis_i_tlast  in  NUM_STREAMS  per-input last.
- axis_i_tdata  in  NUM_STREAMS*AXIS_BYTES*8  packed inputs; stream i occupies bits [(i+1)*W-1 -: W].
- axis_o_tready  in  1  output ready.
- axis_o_tvalid  out  1  output valid.
- axis_o_tlast  out  1  output last.
- axis_o_tdata  out  AXIS_BYTES*8  output data.
- axis_o_tid  out  ID_W  index of the granted input.

## Operation
- Registered state:
  - state: IDLE or LOCKED.
  - grant: ID_W bits.
  - last: ID_W bits, the most recently completed grant.
- IDLE:
  - All axis_i_tready = 0 and axis_o_tvalid = 0.
  - If any axis_i_tvalid is high, pick the first valid index scanning last+1, last+2, … with wrap modulo NUM_STREAMS.
  - Load that index into grant and move to LOCKED on the next edge.
  - If no input is valid, stay in IDLE.
- LOCKED:
  - axis_o_tvalid = axis_i_tvalid[grant].
  - axis_o_tdata, axis_o_tlast = the granted input's fields; axis_o_tid = grant.
  - axis_i_tready[grant] = axis_o_tready; all other tready bits are 0.
  - Purely combinational passthrough with no storage.
- Packet end: when axis_o_tvalid && axis_o_tready && axis_o_tlast, load last = grant and return to IDLE.
- Mid-packet valid gaps: the grant is held. The output shows tvalid = 0 and no other input is serviced.
- Mux select: axis_o_tdata, axis_o_tlast and axis_o_tid always reflect grant, including in IDLE. Only tvalid is gated.
- NUM_STREAMS = 1: degenerates to a passthrough with one IDLE bubble per packet. tid is constantly 0.

## Timing
- Reset (sreset high at an edge):
  - state = IDLE, grant = 0, last = NUM_STREAMS-1, so input 0 has first priority.
  - Resulting outputs: axis_o_tvalid = 0, axis_i_tready = 0, axis_o_tid = 0.
  - axis_o_tdata and axis_o_tlast follow input 0.
- Reset mid-packet: takes effect at that edge. The partial packet is abandoned with no flush and the round-robin pointer is reinitialised.
- Arbitration latency: 1 cycle. An input asserting valid in IDLE at cycle n can transfer its first beat at cycle n+1 at the earliest.
- Throughput:
  - An L-beat packet occupies L+1 cycles minimum: one IDLE bubble per packet.
  - Within a packet, one beat per cycle while valid and ready are both high.
- Single-beat packet (tlast on the first beat): LOCKED for exactly one accepting cycle, then IDLE.
- Simultaneous requests: resolved strictly by the round-robin order from last+1. No input waits more than NUM_STREAMS-1 packets.
- Combinational paths:
  - axis_o_tready → axis_i_tready.
  - axis_i_tvalid/tdata/tlast → output.
  - There is no combinational path from any input valid to any input ready.
- Inputs must obey AXI stream rules: valid held until accepted. The block does not sample non-granted inputs beyond arbitration.

## Test plan
- Reset check: assert sreset 2 cycles with all inputs valid → tvalid=0, all tready=0, tid=0. First grant goes to input 0 one cycle after release.
- Round-robin fairness: NUM_STREAMS=4, all inputs continuously offering 3-beat packets with tdata = {idx, beat}, output always ready → tid order 0,1,2,3,0…. Each packet takes 4 cycles (3 beats + 1 bubble), and packets are never interleaved.
- Backpressure and gaps: input 2 sends 4 beats A0–A3, valid dropped for 2 cycles after A1, output ready toggling 1,0 → output carries exactly A0–A3 in order. Input 1, valid throughout, is not serviced until the cycle after A3's tlast is accepted.
- Single-beat packets: inputs 0 and 3 alternate 1-beat packets → tid sequence 0,3,0,3, one transfer every 2 cycles.
- Reset mid-packet: sreset asserted after beat 2 of 5 from input 1 → next cycle tvalid=0 and all tready=0. After release the first grant goes to the lowest-indexed valid input.
- Idle request: no inputs valid for 10 cycles, then only input 1 valid with a 1-beat packet → tvalid stays 0 for the 10 cycles. The beat appears with tid=1 exactly one cycle after its valid rises.
